// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh NIC traffic engine: flit header layout,
// direction encodings, TX state type and small helper functions.
package mesh_pkg;

    // Flit bit positions; header occupies [63:32], payload [31:0]
    localparam int HDR_VC       = 63;
    localparam int HDR_DX       = 62;
    localparam int HDR_DY       = 61;
    localparam int HDR_HX_LSB   = 52;
    localparam int HDR_HY_LSB   = 48;
    localparam int HDR_SRCX_LSB = 40;
    localparam int HDR_SRCY_LSB = 32;
    localparam int TAG_MSB      = 31;
    localparam int TAG_LSB      = 16;
    localparam int SEQ_MSB      = 15;

    // Direction bit encodings
    localparam logic DIR_EAST  = 1'b0;
    localparam logic DIR_WEST  = 1'b1;
    localparam logic DIR_NORTH = 1'b0;
    localparam logic DIR_SOUTH = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StSend,
        StGap,
        StFin
    } tx_state_e;

    // One-hot hop code; the router shifts it right once per hop
    function automatic logic [3:0] hop_encode(input logic [31:0] n);
        case (n)
            32'd1:   return 4'b0001;
            32'd2:   return 4'b0010;
            32'd3:   return 4'b0100;
            32'd4:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mesh_node_traffic_gen_if.sv
// PE link between a NIC (master) and its router port (slave).
interface mesh_node_traffic_gen_if #(
    parameter int unsigned DATA_W = 64
) ();
    logic              pe_si;
    logic [DATA_W-1:0] pe_di;
    logic              pe_ri;
    logic              pe_polarity;
    logic              pe_so;
    logic [DATA_W-1:0] pe_do;
    logic              pe_ro;

    modport master (
        output pe_si, pe_di, pe_ro,
        input  pe_ri, pe_polarity, pe_so, pe_do
    );

    modport slave (
        input  pe_si, pe_di, pe_ro,
        output pe_ri, pe_polarity, pe_so, pe_do
    );
endinterface

// File: rtl/mesh_rx_fifo.sv
// Eject FIFO. A push while full is accepted only when a pop frees a slot in
// the same cycle; a pop while empty is ignored.
module mesh_rx_fifo #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int unsigned AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [RX_DEPTH];
    logic              push_ok, pop_ok;

    assign full  = (cnt_q == (AW+1)'(RX_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next state; pointers wrap modulo RX_DEPTH
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Pointer registers, flushed by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/mesh_node_traffic_gen.sv
// Per-node NIC traffic engine: builds XY-offset flits and injects bursts on
// the PE port; buffers, tag-checks and counts ejected flits. DATA_W >= 64.
module mesh_node_traffic_gen
    import mesh_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned HOP_W    = 4,
    parameter int unsigned MY_X     = 0,
    parameter int unsigned MY_Y     = 0,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned GAP      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              cfg_dst_x,
    input  logic [7:0]              cfg_dst_y,
    input  logic [15:0]             cfg_npkts,
    input  logic [15:0]             cfg_tag,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [15:0]             tx_count,
    mesh_node_traffic_gen_if.master pe,
    input  logic                    rx_pop,
    output logic                    rx_valid,
    output logic [DATA_W-1:0]       rx_flit,
    output logic [15:0]             rx_count,
    output logic [15:0]             rx_err_count
);
    tx_state_e         state_q, state_d;
    logic [63:0]       hdr_q, hdr_d, hdr_new;
    logic [15:0]       tag_q, tag_d, npkts_q, npkts_d, gap_cnt_q, gap_cnt_d;
    logic [15:0]       tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic [15:0]       rx_err_q, rx_err_d;
    logic              pe_si_q, pe_si_d, busy_q, busy_d, done_q, done_d;
    logic              cfg_err_q, cfg_err_d, launch;
    logic [DATA_W-1:0] pe_di_q, pe_di_d;
    logic [31:0]       dst_x32, dst_y32, dx_abs, dy_abs;
    logic              west, south, cfg_bad;
    logic              fifo_full, fifo_empty, rx_accept;

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign tx_count     = tx_count_q;
    assign pe.pe_si     = pe_si_q;
    assign pe.pe_di     = pe_di_q;
    assign pe.pe_ro     = ~reset & ~fifo_full;
    assign rx_valid     = ~fifo_empty;
    assign rx_count     = rx_count_q;
    assign rx_err_count = rx_err_q;

    // Destination legality check and header template from the cfg inputs
    always_comb begin
        dst_x32 = 32'(cfg_dst_x);
        dst_y32 = 32'(cfg_dst_y);
        west    = dst_x32 < MY_X;
        south   = dst_y32 > MY_Y;
        dx_abs  = west ? MY_X - dst_x32 : dst_x32 - MY_X;
        dy_abs  = south ? dst_y32 - MY_Y : MY_Y - dst_y32;
        cfg_bad = (dst_x32 == MY_X && dst_y32 == MY_Y) || dst_x32 >= COLS || dst_y32 >= ROWS
                  || dx_abs > HOP_W || dy_abs > HOP_W;
        hdr_new = '0;
        hdr_new[HDR_DX] = west ? DIR_WEST : DIR_EAST;
        hdr_new[HDR_DY] = south ? DIR_SOUTH : DIR_NORTH;
        hdr_new[HDR_HX_LSB +: 4]   = hop_encode(dx_abs);
        hdr_new[HDR_HY_LSB +: 4]   = hop_encode(dy_abs);
        hdr_new[HDR_SRCX_LSB +: 8] = 8'(MY_X);
        hdr_new[HDR_SRCY_LSB +: 8] = 8'(MY_Y);
    end

    // TX FSM next state; launch registers one flit and bumps tx_count
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        tag_d      = tag_q;
        npkts_d    = npkts_q;
        gap_cnt_d  = gap_cnt_q;
        tx_count_d = tx_count_q;
        pe_si_d    = 1'b0;
        pe_di_d    = pe_di_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        launch     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d = 1'b0;
                        if (cfg_npkts != 16'd0) begin
                            hdr_d      = hdr_new;
                            tag_d      = cfg_tag;
                            npkts_d    = cfg_npkts;
                            tx_count_d = '0;
                            busy_d     = 1'b1;
                            state_d    = StWait;
                        end
                    end
                end
            end
            StWait: launch = pe.pe_ri;
            StSend: begin
                // tx_count already includes the flit on the wire
                if (tx_count_q == npkts_q) begin
                    state_d = StFin;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (GAP != 0) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else if (pe.pe_ri) begin
                    launch = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StGap: begin
                if (32'(gap_cnt_q) + 32'd1 >= GAP) state_d = StWait;
                else gap_cnt_d = gap_cnt_q + 16'd1;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (launch) begin
            state_d                   = StSend;
            pe_si_d                   = 1'b1;
            pe_di_d                   = '0;
            pe_di_d[63:0]             = hdr_q;
            pe_di_d[HDR_VC]           = pe.pe_polarity;
            pe_di_d[TAG_MSB:TAG_LSB]  = tag_q;
            pe_di_d[SEQ_MSB:0]        = tx_count_q;
            tx_count_d                = sat_inc16(tx_count_q);
        end
    end

    // Eject accounting; a full FIFO still takes a flit if a pop frees a slot
    always_comb begin
        rx_accept  = pe.pe_so & (~fifo_full | (rx_pop & ~fifo_empty));
        rx_count_d = rx_accept ? sat_inc16(rx_count_q) : rx_count_q;
        rx_err_d   = (rx_accept && pe.pe_do[TAG_MSB:TAG_LSB] != cfg_tag) ?
                     sat_inc16(rx_err_q) : rx_err_q;
    end

    // All engine state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            tag_q      <= '0;
            npkts_q    <= '0;
            gap_cnt_q  <= '0;
            tx_count_q <= '0;
            pe_si_q    <= 1'b0;
            pe_di_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rx_count_q <= '0;
            rx_err_q   <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            tag_q      <= tag_d;
            npkts_q    <= npkts_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_count_q <= tx_count_d;
            pe_si_q    <= pe_si_d;
            pe_di_q    <= pe_di_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            rx_count_q <= rx_count_d;
            rx_err_q   <= rx_err_d;
        end
    end

    mesh_rx_fifo #(
        .DATA_W   (DATA_W),
        .RX_DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_accept),
        .push_data (pe.pe_do),
        .pop       (rx_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rx_flit)
    );
endmodule

// File: tb/tb_mesh_node_traffic_gen.sv
// Bench: node A (3,0) injects; node B (1,2) ejects, fed either by A through
// a 2-cycle link or directly by the bench. Scoreboard queues hold expected flits.
module tb_mesh_node_traffic_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    logic        a_start, a_ri, a_pol, b_so, b_pop, use_link;
    logic [7:0]  a_dx, a_dy;
    logic [15:0] a_n, a_tag, b_tag;
    logic [63:0] b_do;
    logic        zero = 1'b0;

    logic        a_busy, a_done, a_err, a_rxv, b_busy, b_done, b_err, b_rxv;
    logic [15:0] a_txc, a_rxc, a_rxe, b_txc, b_rxc, b_rxe;
    logic [63:0] a_rxf, b_rxf;

    logic        d1_si, d2_si;
    logic [63:0] d1_do, d2_do;

    logic [63:0] exp_tx[$];
    logic [63:0] exp_rx[$];

    mesh_node_traffic_gen_if #(.DATA_W(64)) if_a ();
    mesh_node_traffic_gen_if #(.DATA_W(64)) if_b ();

    assign if_a.pe_ri       = a_ri;
    assign if_a.pe_polarity = a_pol;
    assign if_a.pe_so       = 1'b0;
    assign if_a.pe_do       = '0;
    assign if_b.pe_ri       = 1'b0;
    assign if_b.pe_polarity = 1'b0;
    assign if_b.pe_so       = use_link ? d2_si : b_so;
    assign if_b.pe_do       = use_link ? d2_do : b_do;

    // Ideal 2-cycle link A -> B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1_si <= 1'b0; d2_si <= 1'b0; d1_do <= '0; d2_do <= '0;
        end else begin
            d1_si <= if_a.pe_si; d2_si <= d1_si; d1_do <= if_a.pe_di; d2_do <= d1_do;
        end
    end

    mesh_node_traffic_gen #(
        .ROWS(4), .COLS(4), .DATA_W(64), .HOP_W(4), .MY_X(3), .MY_Y(0), .RX_DEPTH(4), .GAP(0)
    ) u_a (
        .clk(clk), .reset(reset), .start(a_start), .cfg_dst_x(a_dx), .cfg_dst_y(a_dy),
        .cfg_npkts(a_n), .cfg_tag(a_tag), .busy(a_busy), .done(a_done), .cfg_err(a_err),
        .tx_count(a_txc), .pe(if_a), .rx_pop(zero), .rx_valid(a_rxv), .rx_flit(a_rxf),
        .rx_count(a_rxc), .rx_err_count(a_rxe)
    );

    mesh_node_traffic_gen #(
        .ROWS(4), .COLS(4), .DATA_W(64), .HOP_W(4), .MY_X(1), .MY_Y(2), .RX_DEPTH(4), .GAP(0)
    ) u_b (
        .clk(clk), .reset(reset), .start(zero), .cfg_dst_x(8'd0), .cfg_dst_y(8'd0),
        .cfg_npkts(16'd0), .cfg_tag(b_tag), .busy(b_busy), .done(b_done), .cfg_err(b_err),
        .tx_count(b_txc), .pe(if_b), .rx_pop(b_pop), .rx_valid(b_rxv), .rx_flit(b_rxf),
        .rx_count(b_rxc), .rx_err_count(b_rxe)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tx(input logic [63:0] f);
        exp_tx.push_back(f);
        if (use_link) exp_rx.push_back(f);
    endtask

    task automatic start_a(input logic [7:0] x, input logic [7:0] y, input logic [15:0] n,
                           input logic [15:0] tag);
        a_dx = x; a_dy = y; a_n = n; a_tag = tag; a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_tx.delete();
        exp_rx.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    // Monitor: check every injected flit and every popped eject-FIFO head
    always @(negedge clk) begin
        logic [63:0] e;
        if (if_a.pe_si === 1'b1) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", 64'(if_a.pe_si), 64'd0);
            else begin e = exp_tx.pop_front(); chk("tx_flit", if_a.pe_di, e); end
        end
        if (b_pop === 1'b1 && b_rxv === 1'b1) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", 64'(b_rxv), 64'd0);
            else begin e = exp_rx.pop_front(); chk("rx_flit", b_rxf, e); end
        end
    end

    initial begin
        logic [63:0] f;
        reset = 1'b1;
        a_start = 0; a_ri = 0; a_pol = 0; b_so = 0; b_pop = 0; use_link = 0;
        a_dx = 0; a_dy = 0; a_n = 0; a_tag = 0; b_tag = 0; b_do = '0;
        tick();
        chk("ro_in_reset", 64'(if_b.pe_ro), 0);
        reset = 1'b0;
        #1;
        chk("rst_ro", 64'(if_b.pe_ro), 1);
        chk("rst_busy", 64'(a_busy), 0);
        chk("rst_done", 64'(a_done), 0);
        chk("rst_err", 64'(a_err), 0);
        chk("rst_txc", 64'(a_txc), 0);
        chk("rst_si", 64'(if_a.pe_si), 0);
        chk("rst_di", if_a.pe_di, 0);
        chk("rst_rxv", 64'(b_rxv), 0);
        chk("rst_rxf", b_rxf, 0);
        chk("rst_rxc", 64'(b_rxc), 0);
        chk("rst_rxe", 64'(b_rxe), 0);

        // Single packet (3,0) -> (1,2): West, South, 2+2 hops
        a_ri = 1; a_pol = 0; use_link = 1; b_tag = 16'hDEAD; b_pop = 1;
        expect_tx(64'h6022_0300_DEAD_0000);
        start_a(8'd1, 8'd2, 16'd1, 16'hDEAD);
        chk("t1_wait_si", 64'(if_a.pe_si), 0);
        chk("t1_busy", 64'(a_busy), 1);
        tick();
        chk("t1_si", 64'(if_a.pe_si), 1);
        chk("t1_txc", 64'(a_txc), 1);
        tick();
        chk("t1_done", 64'(a_done), 1);
        chk("t1_busy_drop", 64'(a_busy), 0);
        chk("t1_si_low", 64'(if_a.pe_si), 0);
        tick();
        chk("t1_done_pulse", 64'(a_done), 0);
        chk("t1_txc_hold", 64'(a_txc), 1);
        repeat (4) tick();
        chk("t1_rxc", 64'(b_rxc), 1);
        chk("t1_rxe", 64'(b_rxe), 0);

        // Loopback burst of 5, back-to-back, VC = 1
        do_reset();
        use_link = 1; a_ri = 1; a_pol = 1; b_tag = 16'h1234; b_pop = 1;
        for (int k = 0; k < 5; k++) expect_tx(64'hE022_0300_1234_0000 | 64'(k));
        start_a(8'd1, 8'd2, 16'd5, 16'h1234);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_b2b_si", 64'(if_a.pe_si), 1);
            tick();
        end
        chk("t2_done", 64'(a_done), 1);
        repeat (6) tick();
        chk("t2_rxc", 64'(b_rxc), 5);
        chk("t2_rxe", 64'(b_rxe), 0);
        chk("t2_rx_drained", 64'(exp_rx.size()), 0);

        // pe_ri held low; VC follows polarity at the launch edge
        do_reset();
        use_link = 0; b_pop = 0; a_ri = 0;
        for (int i = 0; i < 2; i++) begin
            logic p;
            p = (i == 0);
            a_pol = ~p;
            f = 64'h6022_0300_CAFE_0000;
            f[63] = p;
            expect_tx(f);
            start_a(8'd1, 8'd2, 16'd1, 16'hCAFE);
            for (int c = 0; c < 10; c++) begin
                chk("t3_hold_si", 64'(if_a.pe_si), 0);
                tick();
            end
            a_ri = 1; a_pol = p;
            tick();
            chk("t3_si", 64'(if_a.pe_si), 1);
            a_pol = ~p; a_ri = 0;
            tick();
            chk("t3_done", 64'(a_done), 1);
            tick();
        end

        // Eject FIFO fill, full push+pop, drop, drain, empty push+pop
        do_reset();
        use_link = 0; b_tag = 16'h1234; b_pop = 0;
        for (int i = 0; i < 4; i++) begin
            b_do = 64'h0000_0000_1234_0000 + 64'(i);
            exp_rx.push_back(b_do);
            b_so = 1;
            tick();
            chk("t4_ro", 64'(if_b.pe_ro), (i < 3) ? 64'd1 : 64'd0);
        end
        b_so = 0;
        chk("t4_rxc4", 64'(b_rxc), 4);
        b_do = 64'h0000_0000_1234_0004;
        exp_rx.push_back(b_do);
        b_so = 1; b_pop = 1;
        tick();
        b_so = 0; b_pop = 0;
        chk("t4_pp_ro", 64'(if_b.pe_ro), 0);
        chk("t4_pp_rxc", 64'(b_rxc), 5);
        b_do = 64'h0000_0000_1234_0099;
        b_so = 1;
        tick();
        b_so = 0;
        chk("t4_drop_rxc", 64'(b_rxc), 5);
        b_pop = 1;
        repeat (4) tick();
        b_pop = 0;
        chk("t4_empty", 64'(b_rxv), 0);
        chk("t4_ro_back", 64'(if_b.pe_ro), 1);
        chk("t4_rx_drained", 64'(exp_rx.size()), 0);
        b_do = 64'h0000_0000_BAD0_0007;
        exp_rx.push_back(b_do);
        b_so = 1; b_pop = 1;
        tick();
        b_so = 0; b_pop = 0;
        chk("t4_ep_valid", 64'(b_rxv), 1);
        chk("t4_ep_rxc", 64'(b_rxc), 6);
        chk("t4_ep_rxe", 64'(b_rxe), 1);
        b_pop = 1;
        tick();
        b_pop = 0;
        chk("t4_ep_gone", 64'(b_rxv), 0);

        // Illegal destinations, clearing, and npkts = 0
        do_reset();
        use_link = 0; a_ri = 1; a_pol = 0;
        start_a(8'd3, 8'd0, 16'd1, 16'h1111);
        chk("t5_self_err", 64'(a_err), 1);
        chk("t5_self_busy", 64'(a_busy), 0);
        repeat (3) begin tick(); chk("t5_self_si", 64'(if_a.pe_si), 0); end
        expect_tx(64'h6022_0300_2222_0000);
        start_a(8'd1, 8'd2, 16'd1, 16'h2222);
        chk("t5_err_clr", 64'(a_err), 0);
        repeat (2) tick();
        chk("t5_done", 64'(a_done), 1);
        tick();
        start_a(8'd7, 8'd0, 16'd1, 16'h3333);
        chk("t5_x7_err", 64'(a_err), 1);
        chk("t5_x7_busy", 64'(a_busy), 0);
        repeat (3) begin tick(); chk("t5_x7_si", 64'(if_a.pe_si), 0); end
        start_a(8'd1, 8'd2, 16'd0, 16'h5555);
        chk("t5_n0_err", 64'(a_err), 0);
        chk("t5_n0_busy", 64'(a_busy), 0);
        repeat (3) begin tick(); chk("t5_n0_done", 64'(a_done), 0); end

        // Reset in the middle of an 8-packet burst
        do_reset();
        use_link = 0; b_tag = 16'h4444; b_pop = 0;
        b_do = 64'h0000_0000_4444_0000; b_so = 1;
        tick();
        b_so = 0;
        chk("t6_pre_rxc", 64'(b_rxc), 1);
        a_ri = 1; a_pol = 0;
        for (int k = 0; k < 8; k++) expect_tx(64'h6022_0300_4444_0000 | 64'(k));
        start_a(8'd1, 8'd2, 16'd8, 16'h4444);
        repeat (2) tick();
        chk("t6_txc2", 64'(a_txc), 2);
        #2 reset = 1'b1;
        #1;
        exp_tx.delete();
        chk("t6_si", 64'(if_a.pe_si), 0);
        chk("t6_txc", 64'(a_txc), 0);
        chk("t6_busy", 64'(a_busy), 0);
        chk("t6_rxc", 64'(b_rxc), 0);
        chk("t6_rxv", 64'(b_rxv), 0);
        chk("t6_ro", 64'(if_b.pe_ro), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t6_no_done", 64'(a_done), 0);
            chk("t6_no_si", 64'(if_a.pe_si), 0);
        end

        chk("end_tx_q", 64'(exp_tx.size()), 0);
        chk("end_rx_q", 64'(exp_rx.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
